my_cpu_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the control decoder: it owns the program counter, issues word requests to instruction memory over a ready/request handshake, and holds the fetched instruction for decode. Its `inst[6:2]`, `inst[14:12]` and `inst[30]` drive the decoder's OPcode, Fun3 and Fun7. It also takes the decoder's Jump, Branch and PCOffset outputs back from execute to redirect the PC.

---
 rtl/my_cpu_fetch_pkg.sv | 26 ++
 rtl/my_cpu_pc_target.sv | 26 ++
 rtl/my_cpu_fetch.sv | 139 +++++++++++++
 tb/tb_my_cpu_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/my_cpu_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
`default_nettype none

package my_cpu_fetch_pkg;

  localparam logic [1:0]  FETCH_FETCH = 2'd0;
  localparam logic [1:0]  FETCH_HOLD  = 2'd1;
  localparam logic [1:0]  FETCH_DRAIN = 2'd2;
  localparam logic [1:0]  FETCH_HALT  = 2'd3;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = FETCH_FETCH,
    ST_HOLD  = FETCH_HOLD,
    ST_DRAIN = FETCH_DRAIN,
    ST_HALT  = FETCH_HALT
  } fetch_state_e;

  function automatic logic word_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/my_cpu_pc_target.sv
// Redirect target and alignment check for jumps and taken branches.
`default_nettype none

module my_cpu_pc_target
  import my_cpu_fetch_pkg::*;
(
  input  logic        PCOffset,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] alu_result,
  output logic [31:0] target,
  output logic        misalign
);

  always_comb begin
    if (PCOffset) begin
      target = {alu_result[31:1], 1'b0};
    end else begin
      target = ex_pc + ex_imm;
    end
    misalign = word_misaligned(target);
  end

endmodule

`default_nettype wire

// File: rtl/my_cpu_fetch.sv
// Multicycle instruction fetch: owns the PC, handshakes with instruction
// memory, holds the fetched word for decode and applies execute redirects.
`default_nettype none

module my_cpu_fetch
  import my_cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  input  logic        id_ready,
  input  logic        ex_valid,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        PCOffset,
  input  logic        br_cond,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] alu_result,
  output logic        fetch_misalign
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  drain_addr, drain_addr_next;
  logic [31:0]  inst_next, inst_pc_next;
  logic         misalign_next;
  logic         redirect;
  logic [31:0]  target;
  logic         target_misalign;

  my_cpu_pc_target u_pc_target (
    .PCOffset   (PCOffset),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .alu_result (alu_result),
    .target     (target),
    .misalign   (target_misalign)
  );

  assign redirect = ex_valid & (Jump | (Branch & br_cond));
  assign pc_plus4 = inst_pc + 32'd4;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    drain_addr_next = drain_addr;
    inst_next       = inst;
    inst_pc_next    = inst_pc;
    misalign_next   = fetch_misalign;
    imem_req        = 1'b0;
    imem_addr       = pc;
    inst_valid      = 1'b0;

    unique case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_next       = target;
          misalign_next = target_misalign;
          // An unanswered request must stay up, so even a bad target drains first.
          if (!imem_ready) begin
            drain_addr_next = pc;
            state_next      = ST_DRAIN;
          end else if (target_misalign) begin
            state_next = ST_HALT;
          end
        end else if (imem_ready) begin
          inst_next    = imem_rdata;
          inst_pc_next = pc;
          pc_next      = pc + 32'd4;
          state_next   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        inst_valid = 1'b1;
        if (redirect) begin
          pc_next       = target;
          misalign_next = target_misalign;
          state_next    = target_misalign ? ST_HALT : ST_FETCH;
        end else if (id_ready) begin
          state_next = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        // Once a bad target is recorded, pc keeps it for debug.
        if (redirect && !fetch_misalign) begin
          pc_next       = target;
          misalign_next = target_misalign;
        end
        if (imem_ready) begin
          state_next = misalign_next ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase

    if (rst) begin
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_FETCH;
      pc             <= RESET_PC;
      drain_addr     <= RESET_PC;
      inst           <= INST_NOP;
      inst_pc        <= RESET_PC;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      drain_addr     <= drain_addr_next;
      inst           <= inst_next;
      inst_pc        <= inst_pc_next;
      fetch_misalign <= misalign_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_my_cpu_fetch.sv
// Directed self-checking bench for my_cpu_fetch.
`default_nettype none

module tb_my_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        id_ready;
  logic        ex_valid;
  logic        Jump;
  logic        Branch;
  logic        PCOffset;
  logic        br_cond;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] alu_result;
  logic        fetch_misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  my_cpu_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc_plus4       (pc_plus4),
    .inst_valid     (inst_valid),
    .id_ready       (id_ready),
    .ex_valid       (ex_valid),
    .Jump           (Jump),
    .Branch         (Branch),
    .PCOffset       (PCOffset),
    .br_cond        (br_cond),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .alu_result     (alu_result),
    .fetch_misalign (fetch_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid   = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    PCOffset   = 1'b0;
    br_cond    = 1'b0;
    ex_pc      = 32'h0;
    ex_imm     = 32'h0;
    alu_result = 32'h0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'b0;
    id_ready   = 1'b0;
    clear_ex();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    id_ready   = 1'b0;
    clear_ex();
    tick();
    tick();
    #1;
    chk("rst_req",      {31'b0, imem_req},       32'd0);
    chk("rst_valid",    {31'b0, inst_valid},     32'd0);
    chk("rst_inst",     inst,                    32'h0000_0013);
    chk("rst_inst_pc",  inst_pc,                 32'h0);
    chk("rst_pc_plus4", pc_plus4,                32'h4);
    chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req",  {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         32'h0);

    // Zero-wait memory: one instruction every two cycles.
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imem_rdata = 32'hC0DE_0000 | k;
      #1;
      chk("zw_req",   {31'b0, imem_req},   32'd1);
      chk("zw_addr",  imem_addr,           k * 4);
      chk("zw_novld", {31'b0, inst_valid}, 32'd0);
      tick();
      chk("zw_valid",  {31'b0, inst_valid}, 32'd1);
      chk("zw_inst",   inst,                32'hC0DE_0000 | k);
      chk("zw_instpc", inst_pc,             k * 4);
      chk("zw_plus4",  pc_plus4,            k * 4 + 4);
      chk("zw_noreq",  {31'b0, imem_req},   32'd0);
      tick();
    end

    // Wait states: request and address held until ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("ws_req",   {31'b0, imem_req},   32'd1);
      chk("ws_addr",  imem_addr,           32'h0);
      chk("ws_novld", {31'b0, inst_valid}, 32'd0);
      tick();
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h0040_0093;
    #1;
    chk("ws_req4",  {31'b0, imem_req}, 32'd1);
    chk("ws_addr4", imem_addr,         32'h0);
    tick();
    imem_ready = 1'b0;
    #1;
    chk("ws_valid",  {31'b0, inst_valid}, 32'd1);
    chk("ws_inst",   inst,                32'h0040_0093);
    chk("ws_instpc", inst_pc,             32'h0);

    // Back-pressure: held word stable, no requests.
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid",  {31'b0, inst_valid}, 32'd1);
      chk("bp_inst",   inst,                32'h0040_0093);
      chk("bp_instpc", inst_pc,             32'h0);
      chk("bp_noreq",  {31'b0, imem_req},   32'd0);
      tick();
    end

    // Untaken branch and an invalid jump must not redirect.
    ex_valid = 1'b1; Branch = 1'b1; br_cond = 1'b0; ex_pc = 32'h10; ex_imm = 32'h20;
    tick();
    clear_ex();
    Jump = 1'b1; ex_pc = 32'h10; ex_imm = 32'h20;
    tick();
    clear_ex();
    #1;
    chk("nt_valid",  {31'b0, inst_valid}, 32'd1);
    chk("nt_instpc", inst_pc,             32'h0);

    // JAL during HOLD: held word dropped, next request at 0x30.
    ex_valid = 1'b1; Jump = 1'b1; ex_pc = 32'h10; ex_imm = 32'h20;
    imem_ready = 1'b0;
    tick();
    clear_ex();
    #1;
    chk("jal_valid", {31'b0, inst_valid}, 32'd0);
    chk("jal_req",   {31'b0, imem_req},   32'd1);
    chk("jal_addr",  imem_addr,           32'h30);

    // Redirect while the request at 0x8 is still outstanding.
    do_reset();
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    tick(); tick(); tick(); tick();
    imem_ready = 1'b0;
    ex_valid = 1'b1; Branch = 1'b1; br_cond = 1'b1; ex_pc = 32'h30; ex_imm = 32'h10;
    #1;
    chk("dr_addr0", imem_addr, 32'h8);
    tick();
    clear_ex();
    #1;
    chk("dr_req1",   {31'b0, imem_req},   32'd1);
    chk("dr_addr1",  imem_addr,           32'h8);
    chk("dr_novld1", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("dr_req2",  {31'b0, imem_req}, 32'd1);
    chk("dr_addr2", imem_addr,         32'h8);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rdata = 32'h0000_0513;
    #1;
    chk("dr_novld3", {31'b0, inst_valid}, 32'd0);
    chk("dr_req3",   {31'b0, imem_req},   32'd1);
    chk("dr_addr3",  imem_addr,           32'h40);
    tick();
    chk("dr_valid",  {31'b0, inst_valid}, 32'd1);
    chk("dr_inst",   inst,                32'h0000_0513);
    chk("dr_instpc", inst_pc,             32'h40);
    chk("dr_plus4",  pc_plus4,            32'h44);

    // Redirect in FETCH with ready: returned word dropped.
    tick();
    ex_valid = 1'b1; Jump = 1'b1; ex_pc = 32'h100; ex_imm = 32'h0;
    imem_rdata = 32'hBAD0_0000;
    #1;
    chk("fr_addr0", imem_addr, 32'h44);
    tick();
    clear_ex();
    #1;
    chk("fr_novld", {31'b0, inst_valid}, 32'd0);
    chk("fr_req",   {31'b0, imem_req},   32'd1);
    chk("fr_addr",  imem_addr,           32'h100);
    imem_rdata = 32'h0000_0073;
    id_ready   = 1'b0;
    tick();
    chk("fr_valid",  {31'b0, inst_valid}, 32'd1);
    chk("fr_inst",   inst,                32'h0000_0073);
    chk("fr_instpc", inst_pc,             32'h100);

    // JALR to 0x103 -> 0x102, misaligned: halt until reset.
    ex_valid = 1'b1; Jump = 1'b1; PCOffset = 1'b1; alu_result = 32'h103;
    tick();
    clear_ex();
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ma_flag",  {31'b0, fetch_misalign}, 32'd1);
      chk("ma_noreq", {31'b0, imem_req},       32'd0);
      chk("ma_novld", {31'b0, inst_valid},     32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("ma_rst_flag",  {31'b0, fetch_misalign}, 32'd0);
    chk("ma_rst_noreq", {31'b0, imem_req},       32'd0);
    rst = 1'b0;
    #1;
    chk("ma_rst_req",  {31'b0, imem_req}, 32'd1);
    chk("ma_rst_addr", imem_addr,         32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
